// File: rtl/alu_pkg.sv
// Shared widths, FSM state encoding and ALU opcode constants for the operand loader.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;
  localparam int CTRL_W = 3;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_t;

  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'b101;

  // True for any control code the downstream ALU does not implement.
  function automatic logic op_invalid(input logic [CTRL_W-1:0] code);
    case (code)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: op_invalid = 1'b0;
      default:                                    op_invalid = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; the delay flop's reset value is selectable so a
// level held high through reset can be ignored until it is released.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) sig_q <= RESET_VAL;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Byte-serial loader for ALU operands A and B plus control code, driven by a load button.
module alu_operand_loader
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] din,
  input  logic [CTRL_W-1:0] op_in,
  input  logic              load,
  input  logic              clear,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              valid,
  output logic              op_err,
  output logic [1:0]        phase,
  output logic [1:0]        byte_idx
);

  state_t            state, state_n;
  logic [DATA_W-1:0] a_n, b_n;
  logic [CTRL_W-1:0] ctrl_n;
  logic              valid_n, err_n;
  logic [1:0]        idx_n;
  logic              load_evt;

  // Delay flop resets high so a button held through reset yields no capture.
  rise_detect #(.RESET_VAL(1'b1)) u_load_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (load),
    .rise  (load_evt)
  );

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    a_n     = A;
    b_n     = B;
    ctrl_n  = ALUControl;
    err_n   = op_err;
    valid_n = valid;
    idx_n   = byte_idx;

    if (clear) begin
      state_n = LOAD_A;
      a_n     = '0;
      b_n     = '0;
      ctrl_n  = ALU_ADD;
      err_n   = 1'b0;
      valid_n = 1'b0;
      idx_n   = 2'd0;
    end else begin
      case (state)
        LOAD_A: if (load_evt) begin
          a_n   = {A[DATA_W-BYTE_W-1:0], din};
          idx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) state_n = LOAD_B;
        end
        LOAD_B: if (load_evt) begin
          b_n   = {B[DATA_W-BYTE_W-1:0], din};
          idx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            ctrl_n  = op_in;
            err_n   = op_invalid(op_in);
            valid_n = 1'b1;
            state_n = READY;
          end
        end
        READY: if (load_evt) begin
          // The press that leaves READY is also the first byte of the next A.
          a_n     = {{(DATA_W-BYTE_W){1'b0}}, din};
          b_n     = '0;
          valid_n = 1'b0;
          idx_n   = 2'd1;
          state_n = LOAD_A;
        end
        default: begin
          state_n = LOAD_A;
          valid_n = 1'b0;
          idx_n   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD_A;
      A          <= '0;
      B          <= '0;
      ALUControl <= ALU_ADD;
      op_err     <= 1'b0;
      valid      <= 1'b0;
      byte_idx   <= 2'd0;
    end else begin
      state      <= state_n;
      A          <= a_n;
      B          <= b_n;
      ALUControl <= ctrl_n;
      op_err     <= err_n;
      valid      <= valid_n;
      byte_idx   <= idx_n;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench: directed scenarios plus randomized button traffic against a sequence-level model.
module tb_alu_operand_loader;

  logic        clk = 1'b0;
  logic        reset, load, clear;
  logic [7:0]  din;
  logic [2:0]  op_in;
  logic [31:0] A, B;
  logic [2:0]  ALUControl;
  logic        valid, op_err;
  logic [1:0]  phase, byte_idx;

  int tests = 0;
  int fails = 0;

  alu_operand_loader dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .op_in      (op_in),
    .load       (load),
    .clear      (clear),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .valid      (valid),
    .op_err     (op_err),
    .phase      (phase),
    .byte_idx   (byte_idx)
  );

  always #5 clk = ~clk;

  // Model: bytes entered in the current sequence (0..8), operands built arithmetically.
  logic [31:0] m_a, m_b;
  logic [2:0]  m_ctrl;
  logic        m_ready, m_prev_load;
  int          m_count;

  function automatic logic [72:0] expected();
    logic       err;
    logic [1:0] ph;
    err = !(m_ctrl inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd5});
    ph  = m_ready ? 2'd2 : (m_count < 4 ? 2'd0 : 2'd1);
    return {m_a, m_b, m_ctrl, m_ready, err, ph, 2'(m_count % 4)};
  endfunction

  wire [72:0] observed = {A, B, ALUControl, valid, op_err, phase, byte_idx};

  task automatic model_zero();
    m_a = 0; m_b = 0; m_ctrl = 0; m_ready = 0; m_count = 0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic [2:0] o,
                            input logic l, input logic c, input logic r);
    logic evt;
    if (r) begin
      model_zero();
      m_prev_load = 1'b1;
    end else begin
      evt = l && !m_prev_load;
      m_prev_load = l;
      if (c) model_zero();
      else if (evt) begin
        if (m_ready) begin
          m_ready = 0; m_a = 32'(d); m_b = 0; m_count = 1;
        end else if (m_count < 4) begin
          m_a = (m_a << 8) | 32'(d); m_count++;
        end else begin
          m_b = (m_b << 8) | 32'(d); m_count++;
          if (m_count == 8) begin
            m_ready = 1; m_ctrl = o;
          end
        end
      end
    end
  endtask

  // One clock: inputs driven at the falling edge, outputs settle 1 ns after the rising edge.
  task automatic cyc(input logic [7:0] d, input logic [2:0] o,
                     input logic l, input logic c, input logic r);
    @(negedge clk);
    din = d; op_in = o; load = l; clear = c; reset = r;
    @(posedge clk);
    model_step(d, o, l, c, r);
    #1;
  endtask

  task automatic press(input logic [7:0] d, input logic [2:0] o);
    cyc(d, o, 1'b1, 1'b0, 1'b0);
    cyc(d, o, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (observed !== 73'd0) begin
      fails++;
      $display("FAIL reset_state: got %h want 0", observed);
    end
  endtask

  task automatic test_example();
    logic [7:0] seq [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h05};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      press(seq[i], 3'b001);
      if (i == 3) begin
        tests++;
        if (A !== 32'h12345678 || phase !== 2'd1 || byte_idx !== 2'd0 || valid !== 1'b0) begin
          fails++;
          $display("FAIL example_a_done: A=%h phase=%0d idx=%0d valid=%b want 12345678/1/0/0",
                   A, phase, byte_idx, valid);
        end
      end
    end
    tests++;
    if ({A, B, ALUControl, valid, op_err} !== {32'h12345678, 32'h00000005, 3'b001, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL example_ready: A=%h B=%h ctl=%b valid=%b err=%b want 12345678 00000005 001 1 0",
               A, B, ALUControl, valid, op_err);
    end
    cyc(8'hFF, 3'b110, 1'b0, 1'b0, 1'b0);
    tests++;
    if (ALUControl !== 3'b001 || A !== 32'h12345678 || valid !== 1'b1) begin
      fails++;
      $display("FAIL ready_hold: ctl=%b A=%h valid=%b want 001 12345678 1", ALUControl, A, valid);
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 10; i++) cyc(8'hC3, 3'd0, 1'b1, 1'b0, 1'b0);
    cyc(8'h11, 3'd0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (A !== 32'h000000C3 || byte_idx !== 2'd1) begin
      fails++;
      $display("FAIL load_hold: A=%h idx=%0d want 000000c3 1", A, byte_idx);
    end
  endtask

  task automatic test_bad_op();
    do_reset();
    for (int i = 0; i < 8; i++) press(8'(i + 1), 3'b100);
    tests++;
    if (ALUControl !== 3'b100 || op_err !== 1'b1 || valid !== 1'b1) begin
      fails++;
      $display("FAIL bad_op: ctl=%b err=%b valid=%b want 100 1 1", ALUControl, op_err, valid);
    end
    tests++;
    if (B !== 32'h05060708) begin
      fails++;
      $display("FAIL bad_op_b: B=%h want 05060708", B);
    end
  endtask

  task automatic test_back_to_back();
    // Starts from READY left by test_bad_op.
    cyc(8'hAB, 3'd0, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({valid, A, B, byte_idx, phase} !== {1'b0, 32'h000000AB, 32'h0, 2'd1, 2'd0}) begin
      fails++;
      $display("FAIL ready_restart: valid=%b A=%h B=%h idx=%0d phase=%0d want 0 000000ab 0 1 0",
               valid, A, B, byte_idx, phase);
    end
    tests++;
    if (ALUControl !== 3'b100 || op_err !== 1'b1) begin
      fails++;
      $display("FAIL restart_ctl_kept: ctl=%b err=%b want 100 1", ALUControl, op_err);
    end
    cyc(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear_priority();
    do_reset();
    for (int i = 0; i < 6; i++) press(8'hA0 + 8'(i), 3'd2);
    tests++;
    if (phase !== 2'd1 || byte_idx !== 2'd2) begin
      fails++;
      $display("FAIL clear_setup: phase=%0d idx=%0d want 1 2", phase, byte_idx);
    end
    cyc(8'h77, 3'd2, 1'b1, 1'b1, 1'b0);
    tests++;
    if (observed !== 73'd0) begin
      fails++;
      $display("FAIL clear_vs_load: got %h want 0", observed);
    end
    cyc(8'h77, 3'd2, 1'b1, 1'b0, 1'b0);
    tests++;
    if (observed !== 73'd0) begin
      fails++;
      $display("FAIL clear_no_late_capture: got %h want 0", observed);
    end
    cyc(8'h77, 3'd2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_held_load();
    cyc(8'h5A, 3'd0, 1'b1, 1'b0, 1'b1);
    cyc(8'h5A, 3'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(8'h5A, 3'd0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (observed !== 73'd0) begin
      fails++;
      $display("FAIL reset_held_load: got %h want 0", observed);
    end
    cyc(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(8'h5A, 3'd0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (A !== 32'h0000005A || byte_idx !== 2'd1) begin
      fails++;
      $display("FAIL reset_release_capture: A=%h idx=%0d want 0000005a 1", A, byte_idx);
    end
  endtask

  task automatic test_random();
    logic l = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(2) == 0) l = ~l;
      cyc(8'($urandom_range(255)), 3'($urandom_range(7)), l,
          ($urandom_range(40) == 0), ($urandom_range(150) == 0));
      tests++;
      if (observed !== expected()) begin
        fails++;
        $display("FAIL random_cycle_%0d: got %h want %h", i, observed, expected());
      end
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; clear = 1'b0; din = 8'h00; op_in = 3'd0;
    model_zero();
    m_prev_load = 1'b1;
    test_reset();
    test_example();
    test_hold();
    test_bad_op();
    test_back_to_back();
    test_clear_priority();
    test_reset_held_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
